// File: rtl/ctrl_pkg.sv
// Shared control definitions for the multicycle CPU: arbiter state encoding,
// requester port ids and the legal memory-latency range.
package ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    ACK   = 2'b11
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 7;
  localparam int LAT_CNT_W   = 3;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way picker: a lone requester always wins; on a tie the
// CPU wins in fixed mode, otherwise the port that was not granted last.
module rr_pick2
  import ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed_prio,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = PORT_CPU;
    if (req == 2'b10) begin
      grant_id = PORT_DBG;
    end else if (req == 2'b11) begin
      grant_id = fixed_prio ? PORT_CPU : ~last_grant;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the unified instruction/data memory between the CPU port and the
// debug/loader port; each access runs issue -> latency wait -> one-cycle ack.
module mem_arbiter
  import ctrl_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [1:0]    state
);

  // Out-of-range latencies are clamped so the wait counter never wraps.
  localparam int LAT_C = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                         (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LAT_C);
  localparam logic FIXED_BIT = (FIXED_PRIO != 0);

  arb_state_t           st;
  logic                 owner;
  logic                 last_grant;
  logic [LAT_CNT_W-1:0] cnt;
  logic                 grant_valid;
  logic                 grant_id;

  rr_pick2 u_pick (
    .req         ({dbg_req, cpu_req}),
    .last_grant  (last_grant),
    .fixed_prio  (FIXED_BIT),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      owner      <= PORT_CPU;
      last_grant <= PORT_DBG;
      cnt        <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      cpu_ack    <= 1'b0;
      dbg_ack    <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (grant_valid) begin
            owner     <= grant_id;
            mem_en    <= 1'b1;
            mem_we    <= (grant_id == PORT_DBG) ? dbg_we    : cpu_we;
            mem_addr  <= (grant_id == PORT_DBG) ? dbg_addr  : cpu_addr;
            mem_wdata <= (grant_id == PORT_DBG) ? dbg_wdata : cpu_wdata;
            st        <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          cnt    <= LAT_LOAD;
          st     <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          // The last wait cycle is the one in which mem_rdata is valid.
          if (cnt == LAT_CNT_W'(1)) begin
            if (!mem_we) begin
              if (owner == PORT_DBG) dbg_rdata <= mem_rdata;
              else                   cpu_rdata <= mem_rdata;
            end
            if (owner == PORT_DBG) dbg_ack <= 1'b1;
            else                   cpu_ack <= 1'b1;
            st <= ACK;
          end
        end
        ACK: begin
          cpu_ack    <= 1'b0;
          dbg_ack    <= 1'b0;
          last_grant <= owner;
          st         <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign busy  = (st != IDLE);
  assign state = st;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (latency 1 round-robin,
// latency 3 round-robin, latency 1 fixed priority) share one stimulus stream.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;

  logic [2:0]        cpu_ack, dbg_ack, mem_en, mem_we, busy;
  logic [2:0][31:0]  cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0][1:0]   st;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : {~a[15:0], a[15:0]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 1) ? 3 : 1;
    logic [7:0]  pend;
    logic [31:0] a_lat;

    // Memory model: data is valid only in the cycle L cycles after mem_en.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        pend  <= '0;
        a_lat <= '0;
      end else begin
        pend <= {pend[6:0], mem_en[g]};
        if (mem_en[g]) a_lat <= mem_addr[g];
      end
    end
    assign mem_rdata[g] = pend[L-1] ? mem_word(a_lat) : 32'hBAD0_BAD0;

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(L), .FIXED_PRIO((g == 2) ? 1 : 0)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata[g]),
      .cpu_ack   (cpu_ack[g]),
      .dbg_req   (dbg_req),
      .dbg_we    (dbg_we),
      .dbg_addr  (dbg_addr),
      .dbg_wdata (dbg_wdata),
      .dbg_rdata (dbg_rdata[g]),
      .dbg_ack   (dbg_ack[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g]),
      .state     (st[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset values, then CPU read alone at latency 1 followed by a back-to-back read.
    do_reset();
    chk("rst_state", 32'(st[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_mem_en", 32'(mem_en[0]), 32'd0);
    chk("rst_mem_addr", mem_addr[0], 32'h0);
    chk("rst_cpu_rdata", cpu_rdata[0], 32'h0);
    cpu_req = 1'b1; cpu_addr = 32'h10; cpu_we = 1'b0;
    #1 chk("t1_c0_mem_en", 32'(mem_en[0]), 32'd0);
    tick();
    chk("t1_c1_mem_en", 32'(mem_en[0]), 32'd1);
    chk("t1_c1_mem_addr", mem_addr[0], 32'h10);
    chk("t1_c1_mem_we", 32'(mem_we[0]), 32'd0);
    chk("t1_c1_state", 32'(st[0]), 32'd1);
    tick();
    chk("t1_c2_mem_en", 32'(mem_en[0]), 32'd0);
    chk("t1_c2_cpu_ack", 32'(cpu_ack[0]), 32'd0);
    chk("t1_c2_state", 32'(st[0]), 32'd2);
    tick();
    chk("t1_c3_cpu_ack", 32'(cpu_ack[0]), 32'd1);
    chk("t1_c3_cpu_rdata", cpu_rdata[0], 32'hDEAD_BEEF);
    chk("t1_c3_dbg_ack", 32'(dbg_ack[0]), 32'd0);
    @(negedge clk);
    cpu_addr = 32'h20;
    tick();
    chk("t1_c4_cpu_ack", 32'(cpu_ack[0]), 32'd0);
    chk("t1_c4_state", 32'(st[0]), 32'd0);
    tick();
    chk("t1_c5_mem_en", 32'(mem_en[0]), 32'd1);
    chk("t1_c5_mem_addr", mem_addr[0], 32'h20);
    tick();
    chk("t1_c6_cpu_ack", 32'(cpu_ack[0]), 32'd0);
    tick();
    chk("t1_c7_cpu_ack", 32'(cpu_ack[0]), 32'd1);
    chk("t1_c7_cpu_rdata", cpu_rdata[0], 32'hFFDF_0020);
    @(negedge clk);
    cpu_req = 1'b0;
    tick();
    chk("t1_c8_cpu_ack", 32'(cpu_ack[0]), 32'd0);
    tick();
    chk("t1_c9_mem_en", 32'(mem_en[0]), 32'd0);
    chk("t1_c9_busy", 32'(busy[0]), 32'd0);

    // Debug write at latency 3: rdata registers must not move.
    do_reset();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h40; dbg_wdata = 32'h1234_5678;
    tick();
    chk("t2_c1_mem_en", 32'(mem_en[1]), 32'd1);
    chk("t2_c1_mem_we", 32'(mem_we[1]), 32'd1);
    chk("t2_c1_mem_addr", mem_addr[1], 32'h40);
    chk("t2_c1_mem_wdata", mem_wdata[1], 32'h1234_5678);
    tick();
    chk("t2_c2_mem_en", 32'(mem_en[1]), 32'd0);
    chk("t2_c2_mem_we_hold", 32'(mem_we[1]), 32'd1);
    chk("t2_c2_mem_addr_hold", mem_addr[1], 32'h40);
    tick();
    tick();
    chk("t2_c4_dbg_ack", 32'(dbg_ack[1]), 32'd0);
    tick();
    chk("t2_c5_dbg_ack", 32'(dbg_ack[1]), 32'd1);
    chk("t2_c5_cpu_ack", 32'(cpu_ack[1]), 32'd0);
    chk("t2_c5_dbg_rdata", dbg_rdata[1], 32'h0);
    chk("t2_c5_cpu_rdata", cpu_rdata[1], 32'h0);
    @(negedge clk);
    dbg_req = 1'b0; dbg_we = 1'b0;

    // Continuous tie: round-robin alternates, fixed priority keeps the CPU.
    do_reset();
    cpu_req = 1'b1; cpu_addr = 32'h100;
    dbg_req = 1'b1; dbg_addr = 32'h200;
    for (int c = 1; c <= 15; c++) begin
      tick();
      chk($sformatf("t3_rr_cpu_ack_c%0d", c), 32'(cpu_ack[0]), 32'(c == 3 || c == 11));
      chk($sformatf("t3_rr_dbg_ack_c%0d", c), 32'(dbg_ack[0]), 32'(c == 7 || c == 15));
      chk($sformatf("t3_fp_cpu_ack_c%0d", c), 32'(cpu_ack[2]), 32'(c % 4 == 3));
      chk($sformatf("t3_fp_dbg_ack_c%0d", c), 32'(dbg_ack[2]), 32'd0);
      if (c == 5) chk("t3_rr_c5_mem_addr", mem_addr[0], 32'h200);
      if (c == 7) chk("t3_rr_c7_dbg_rdata", dbg_rdata[0], 32'hFDFF_0200);
      if (c == 11) chk("t3_rr_c11_cpu_rdata", cpu_rdata[0], 32'hFEFF_0100);
    end
    @(negedge clk);
    cpu_req = 1'b0;
    for (int c = 16; c <= 19; c++) begin
      tick();
      chk($sformatf("t3_fp_dbg_ack_c%0d", c), 32'(dbg_ack[2]), 32'(c == 19));
      chk($sformatf("t3_fp_cpu_ack_c%0d", c), 32'(cpu_ack[2]), 32'd0);
    end
    @(negedge clk);
    dbg_req = 1'b0;

    // Reset in the middle of a latency-3 CPU read; then the first tie goes to the CPU.
    do_reset();
    cpu_req = 1'b1; cpu_addr = 32'h30;
    tick();
    tick();
    tick();
    chk("t4_pre_state", 32'(st[1]), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_busy", 32'(busy[1]), 32'd0);
    chk("t4_rst_state", 32'(st[1]), 32'd0);
    chk("t4_rst_mem_addr", mem_addr[1], 32'h0);
    chk("t4_rst_mem_en", 32'(mem_en[1]), 32'd0);
    chk("t4_rst_cpu_ack", 32'(cpu_ack[1]), 32'd0);
    dbg_req = 1'b1; dbg_addr = 32'h44;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("t4_m1_mem_en", 32'(mem_en[1]), 32'd1);
    chk("t4_m1_mem_addr", mem_addr[1], 32'h30);
    tick();
    tick();
    tick();
    chk("t4_m4_cpu_ack", 32'(cpu_ack[1]), 32'd0);
    tick();
    chk("t4_m5_cpu_ack", 32'(cpu_ack[1]), 32'd1);
    chk("t4_m5_dbg_ack", 32'(dbg_ack[1]), 32'd0);
    chk("t4_m5_cpu_rdata", cpu_rdata[1], 32'hFFCF_0030);
    @(negedge clk);
    cpu_req = 1'b0; dbg_req = 1'b0;

    // Inputs changing during WAIT are ignored; arbitration resumes in the next IDLE.
    do_reset();
    cpu_req = 1'b1; cpu_addr = 32'h50;
    tick();
    tick();
    #1;
    cpu_addr = 32'h60; dbg_req = 1'b1; dbg_addr = 32'h70;
    tick();
    chk("t5_c3_mem_addr", mem_addr[1], 32'h50);
    chk("t5_c3_state", 32'(st[1]), 32'd2);
    tick();
    chk("t5_c4_mem_addr", mem_addr[1], 32'h50);
    chk("t5_c4_mem_en", 32'(mem_en[1]), 32'd0);
    tick();
    chk("t5_c5_cpu_ack", 32'(cpu_ack[1]), 32'd1);
    chk("t5_c5_dbg_ack", 32'(dbg_ack[1]), 32'd0);
    chk("t5_c5_cpu_rdata", cpu_rdata[1], 32'hFFAF_0050);
    tick();
    chk("t5_c6_state", 32'(st[1]), 32'd0);
    tick();
    chk("t5_c7_mem_en", 32'(mem_en[1]), 32'd1);
    chk("t5_c7_mem_addr", mem_addr[1], 32'h70);
    @(negedge clk);
    cpu_req = 1'b0; dbg_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
